asu_ddr5_command_encoder: RTL and testbench
===========================================

# asu_ddr5_command_encoder

Initiator-side DDR5 command encoder. It accepts one command request at a time over a valid/ready handshake and serialises it into the two-cycle DFI command format on `dfi_address_o`/`dfi_cs_o`:
- cycle 1 is CS-low with the opcode;
- cycle 2 is CS-high with the payload.

It drives the DFI command inputs of the PHY command/address path and enforces a programmable deselect gap between commands. The first cycle carries the MR address or write address; the second carries the MR operand or write attributes.

## Interface
Parameters:
- pNUM_RANK, 1, number of ranks; width of `dfi_cs_o`
- pGAP, 2, number of extra deselect cycles after each command (0..15)
- RANK_W, `(pNUM_RANK>1)?$clog2(pNUM_RANK):1`, localparam, rank index width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  clock enable; low freezes all state
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_type_i  in  1  0 = MRW, 1 = WRITE
- req_rank_i  in  RANK_W  target rank index
- req_mr_i  in  8  MR address (MRW)
- req_op_i  in  8  MR operand (MRW)
- req_wr_addr_i  in  9  write address field (WRITE)
- req_col_i  in  8  column field (WRITE)
- req_bl_default_i  in  1  1 = use default burst length (WRITE)
- dfi_address_o  out  14  command bus
- dfi_cs_o  out  pNUM_RANK  active-low chip selects
- cmd_done_o  out  1  one-cycle pulse, concurrent with cycle 2
- rank_err_o  out  1  one-cycle pulse, concurrent with cycle 1, when `req_rank_i >= pNUM_RANK`

## Operation
- States: IDLE, C1, C2, GAP.
- Handshake: `req_ready_o = (state==IDLE) & enable_i`, combinational. A request is accepted on the edge where `req_valid_i & req_ready_o`.
- All request fields are registered at accept; the requester may change them afterwards.
- Encodings: MRW opcode 5'b00101, WRITE opcode 5'b01101.
- MRW cycle 1: `{1'b0, req_mr_i, 5'b00101}`. MRW cycle 2: `{3'b000, 1'b0, 2'b00, req_op_i}`; bit 10 = 0 means not cancelled.
- WRITE cycle 1: `{req_wr_addr_i, 5'b01101}`. WRITE cycle 2: `{req_col_i, req_bl_default_i, 5'b00000}`; bit 5 carries the burst-length select.
- CS in cycle 1: bit `req_rank_i` low, all others high. For an invalid rank, all bits stay high, the command is still sequenced, and `rank_err_o` pulses.
- CS in cycle 2: all bits high.
- Deselect (DES): `dfi_cs_o` all ones and `dfi_address_o = 14'h0`. DES is driven in IDLE and GAP.
- Transitions:
  - IDLE → C1 on accept.
  - C1 → C2 unconditionally.
  - C2 → GAP if pGAP > 0, else → IDLE.
  - GAP → IDLE when the 4-bit gap counter reaches 0. The counter is loaded with pGAP−1 on entry to GAP and decrements each enabled cycle.
- `enable_i` low: state, counter and outputs hold their values; no accept occurs.
- Reset, asynchronous, any state: state IDLE; `dfi_cs_o` all ones; `dfi_address_o` 0; `cmd_done_o` 0; `rank_err_o` 0; counter 0. A sequence in progress is abandoned and cycle 2 is never emitted.

## Timing
- All outputs are registered except `req_ready_o`.
- Accept on edge k:
  - cycle 1 is visible after edge k;
  - cycle 2 is visible after edge k+1, together with `cmd_done_o`;
  - DES is visible after edge k+2.
- `req_ready_o` rises again after edge k+2+pGAP. The next accept is therefore at edge k+3+pGAP at the earliest.
- Command period is 3+pGAP cycles. With pGAP=0 there is exactly one DES cycle between commands.
- A request held valid while ready is low waits; no data is lost.

## Configuration
- Macro WRITE_CMD_EN.
- Defined: WRITE requests are supported as above.
- Undefined:
  - `req_wr_addr_i`, `req_col_i` and `req_bl_default_i` are absent.
  - `req_type_i` is ignored and every request is encoded as MRW.
  - No WRITE opcode logic is synthesised.

## Structure
- Package asu_ddr5_pkg holds:
  - localparams CMD_MRW_OP = 5'b00101 and CMD_WR_OP = 5'b01101;
  - the DES address value;
  - typedef enum `req_type_e` {REQ_MRW, REQ_WRITE};
  - typedef enum `enc_state_e` {IDLE, C1, C2, GAP}.
- One sub-module: asu_ddr5_cs_decode. It is combinational and maps a rank index plus a valid flag to an active-low one-hot CS and an out-of-range flag.

## Test plan
- Reset, then idle: `dfi_cs_o` is all ones, `dfi_address_o` is 0, `req_ready_o` is 1.
- MRW with mr=8, op=8'h98, rank 0, pNUM_RANK=1:
  - cycle 1 = 14'h0105 with CS 0;
  - cycle 2 = 14'h0098 with CS 1 and `cmd_done_o` = 1;
  - then pGAP DES cycles.
- WRITE with wr_addr=9'h1A5, col=8'h3C, bl_default=1:
  - cycle 1 = 14'h34AD;
  - cycle 2 = 14'h0F20;
  - both with the correct CS pattern.
- Back-to-back requests with valid held high and pGAP=0: commands are spaced 3 cycles apart with one DES between them, and no request is dropped.
- pNUM_RANK=2 and rank 1, then rank 2 on a build with pNUM_RANK=3:
  - rank 1 gives cycle-1 CS 2'b01;
  - rank 2 gives CS 3'b011, because bit 2 is low for rank 2;
  - an out-of-range index (3) gives CS all ones and a `rank_err_o` pulse.
- Stall and reset:
  - `enable_i` low for 3 cycles in C2 holds the outputs and resumes correctly when it returns high;
  - asserting `rst_i` in C1 forces DES immediately, with no cycle 2 and no `cmd_done_o`.

Source files
------------

// File: rtl/asu_ddr5_command_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asu_ddr5_pkg
// Description : Shared opcodes, deselect value, request/state enums and
//               command-word helpers for the DDR5 command encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package asu_ddr5_pkg;

  localparam logic [4:0]  CMD_MRW_OP = 5'b00101;
  localparam logic [4:0]  CMD_WR_OP  = 5'b01101;
  localparam logic [13:0] DES_ADDR   = 14'h0000;

  typedef enum logic {
    REQ_MRW   = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C1   = 2'd1,
    C2   = 2'd2,
    GAP  = 2'd3
  } enc_state_e;

  // MRW first cycle: MR address above the opcode, bit 13 reserved low.
  function automatic logic [13:0] mrw_cycle1(input logic [7:0] mr);
    return {1'b0, mr, CMD_MRW_OP};
  endfunction

  // MRW second cycle: operand in the low byte, bit 10 low = not cancelled.
  function automatic logic [13:0] mrw_cycle2(input logic [7:0] op);
    return {3'b000, 1'b0, 2'b00, op};
  endfunction

endpackage
`default_nettype wire

// File: rtl/asu_ddr5_command_encoder_cs_decode.sv
`default_nettype none
// ============================================================================
// Module      : asu_ddr5_cs_decode
// Description : Combinational rank decoder. Produces an active-low one-hot
//               chip select for a valid in-range rank index and flags indices
//               beyond the populated rank count (all selects stay high).
// Revision    : 1.0 - initial release
// ============================================================================
module asu_ddr5_cs_decode
  import asu_ddr5_pkg::*;
#(
  parameter int pNUM_RANK = 1,
  parameter int RANK_W    = 1
) (
  input  logic [RANK_W-1:0]    rank_i,
  input  logic                 valid_i,
  output logic [pNUM_RANK-1:0] cs_n_o,
  output logic                 oor_o
);

  // One select line per populated rank; out-of-range indices match none.
  for (genvar i = 0; i < pNUM_RANK; i++) begin : g_cs
    assign cs_n_o[i] = ~(valid_i & (int'(rank_i) == i));
  end

  assign oor_o = valid_i & (int'(rank_i) >= pNUM_RANK);

endmodule
`default_nettype wire

// File: rtl/asu_ddr5_command_encoder.sv
`default_nettype none
// ============================================================================
// Module      : asu_ddr5_command_encoder
// Description : DDR5 initiator command encoder. Accepts one MRW/WRITE request
//               per valid/ready handshake and serialises it into a two-cycle
//               DFI command (CS-low opcode cycle, CS-high payload cycle),
//               followed by a programmable number of deselect cycles.
//               Build macro WRITE_CMD_EN enables WRITE command support; when
//               undefined every request is encoded as MRW.
// Revision    : 1.0 - initial release
// ============================================================================
module asu_ddr5_command_encoder
  import asu_ddr5_pkg::*;
#(
  parameter  int pNUM_RANK = 1,
  parameter  int pGAP      = 2,
  localparam int RANK_W    = (pNUM_RANK > 1) ? $clog2(pNUM_RANK) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_type_i,
  input  logic [RANK_W-1:0]    req_rank_i,
  input  logic [7:0]           req_mr_i,
  input  logic [7:0]           req_op_i,
`ifdef WRITE_CMD_EN
  input  logic [8:0]           req_wr_addr_i,
  input  logic [7:0]           req_col_i,
  input  logic                 req_bl_default_i,
`endif
  output logic [13:0]          dfi_address_o,
  output logic [pNUM_RANK-1:0] dfi_cs_o,
  output logic                 cmd_done_o,
  output logic                 rank_err_o
);

  // Gap counter reload; a zero gap never enters GAP so the value is unused.
  localparam logic [3:0] GAP_LOAD = (pGAP > 0) ? 4'(pGAP - 1) : 4'd0;

  enc_state_e           state_q, state_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [13:0]          addr_q, addr_d;
  logic [13:0]          payload_q, payload_d;
  logic [pNUM_RANK-1:0] cs_q, cs_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic [13:0]          cycle1_word;
  logic [13:0]          cycle2_word;
  logic [pNUM_RANK-1:0] cs_sel;
  logic                 rank_oor;

  assign req_ready_o = (state_q == IDLE) & enable_i;
  assign accept      = req_valid_i & req_ready_o;

  asu_ddr5_cs_decode #(
    .pNUM_RANK (pNUM_RANK),
    .RANK_W    (RANK_W)
  ) u_cs_decode (
    .rank_i  (req_rank_i),
    .valid_i (accept),
    .cs_n_o  (cs_sel),
    .oor_o   (rank_oor)
  );

`ifdef WRITE_CMD_EN
  // Build both command words from the live request; captured only on accept.
  always_comb begin
    cycle1_word = mrw_cycle1(req_mr_i);
    cycle2_word = mrw_cycle2(req_op_i);
    if (req_type_e'(req_type_i) == REQ_WRITE) begin
      cycle1_word = {req_wr_addr_i, CMD_WR_OP};
      cycle2_word = {req_col_i, req_bl_default_i, 5'b00000};
    end
  end
`else
  logic unused_req_type;
  assign unused_req_type = req_type_i;

  // MRW-only build: the request type is ignored.
  always_comb begin
    cycle1_word = mrw_cycle1(req_mr_i);
    cycle2_word = mrw_cycle2(req_op_i);
  end
`endif

  // Next-state and next-output computation for the command sequencer.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    addr_d    = DES_ADDR;
    payload_d = payload_q;
    cs_d      = '1;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = C1;
          addr_d    = cycle1_word;
          payload_d = cycle2_word;
          cs_d      = cs_sel;
          err_d     = rank_oor;
        end
      end
      C1: begin
        state_d = C2;
        addr_d  = payload_q;
        done_d  = 1'b1;
      end
      C2: begin
        if (pGAP > 0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs; enable low freezes everything.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      gap_cnt_q <= 4'd0;
      addr_q    <= DES_ADDR;
      payload_q <= 14'h0000;
      cs_q      <= '1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (enable_i) begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dfi_address_o = addr_q;
  assign dfi_cs_o      = cs_q;
  assign cmd_done_o    = done_q;
  assign rank_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_asu_ddr5_command_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_asu_ddr5_command_encoder
// Description : Self-checking bench. Instance A: 3 ranks, gap 2. Instance B:
//               1 rank, gap 0. Per-cycle expected outputs are queued when a
//               request is driven and compared on each falling edge.
//               Honours WRITE_CMD_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asu_ddr5_command_encoder;

  typedef struct {
    logic [13:0] addr;
    logic [2:0]  cs;
    logic        done;
    logic        err;
    logic        rdy;
    int          step;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        req_type;
  logic [7:0]  mr, op;
  logic [8:0]  wr_addr;
  logic [7:0]  col;
  logic        bl;

  logic        a_valid, a_ready, a_done, a_err;
  logic [1:0]  a_rank;
  logic [13:0] a_addr;
  logic [2:0]  a_cs;

  logic        b_valid, b_ready, b_done, b_err;
  logic [0:0]  b_rank;
  logic [13:0] b_addr;
  logic [0:0]  b_cs;

  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  asu_ddr5_command_encoder #(.pNUM_RANK(3), .pGAP(2)) dut_a (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .enable_i         (en),
    .req_valid_i      (a_valid),
    .req_ready_o      (a_ready),
    .req_type_i       (req_type),
    .req_rank_i       (a_rank),
    .req_mr_i         (mr),
    .req_op_i         (op),
`ifdef WRITE_CMD_EN
    .req_wr_addr_i    (wr_addr),
    .req_col_i        (col),
    .req_bl_default_i (bl),
`endif
    .dfi_address_o    (a_addr),
    .dfi_cs_o         (a_cs),
    .cmd_done_o       (a_done),
    .rank_err_o       (a_err)
  );

  asu_ddr5_command_encoder #(.pNUM_RANK(1), .pGAP(0)) dut_b (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .enable_i         (en),
    .req_valid_i      (b_valid),
    .req_ready_o      (b_ready),
    .req_type_i       (req_type),
    .req_rank_i       (b_rank),
    .req_mr_i         (mr),
    .req_op_i         (op),
`ifdef WRITE_CMD_EN
    .req_wr_addr_i    (wr_addr),
    .req_col_i        (col),
    .req_bl_default_i (bl),
`endif
    .dfi_address_o    (b_addr),
    .dfi_cs_o         (b_cs),
    .cmd_done_o       (b_done),
    .rank_err_o       (b_err)
  );

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic [13:0] addr,
                     input logic [2:0] cs, input logic done, input logic err,
                     input logic rdy);
    chk($sformatf("%s_s%0d_addr", who, e.step), addr, e.addr);
    chk($sformatf("%s_s%0d_cs", who, e.step), 14'(cs), 14'(e.cs));
    chk($sformatf("%s_s%0d_done", who, e.step), 14'(done), 14'(e.done));
    chk($sformatf("%s_s%0d_err", who, e.step), 14'(err), 14'(e.err));
    chk($sformatf("%s_s%0d_ready", who, e.step), 14'(rdy), 14'(e.rdy));
  endtask

  // Monitor: one expected entry per falling edge while entries are pending.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      cmp("A", ea, a_addr, a_cs, a_done, a_err, a_ready);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      cmp("B", eb, b_addr, {2'b00, b_cs}, b_done, b_err, b_ready);
    end
  end

  task automatic push_a(input logic [13:0] addr, input logic [2:0] cs,
                        input logic done, input logic err, input logic rdy);
    exp_t e;
    e.addr = addr; e.cs = cs; e.done = done; e.err = err; e.rdy = rdy; e.step = step;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [13:0] addr, input logic cs,
                        input logic done, input logic err, input logic rdy);
    exp_t e;
    e.addr = addr; e.cs = {2'b00, cs}; e.done = done; e.err = err; e.rdy = rdy; e.step = step;
    qb.push_back(e);
  endtask

  task automatic scramble();
    mr      = 8'($urandom);
    op      = 8'($urandom);
    wr_addr = 9'($urandom);
    col     = 8'($urandom);
    bl      = 1'($urandom);
    req_type = 1'($urandom);
  endtask

  // Wait (bounded) until both queues are consumed; ends at posedge + 1.
  task automatic drain();
    for (int i = 0; i < 60 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    checks++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout step=%0d pending_a=%0d pending_b=%0d", step, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Single command on A (gap 2). Called at posedge + 1 with fields set.
  task automatic cmd_a(input logic typ, input logic [1:0] rank, input logic [13:0] c1,
                       input logic [13:0] c2, input logic [2:0] cs1, input logic err);
    req_type = typ; a_rank = rank; a_valid = 1'b1;
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    push_a(c1, cs1, 1'b0, err, 1'b0);
    push_a(c2, 3'b111, 1'b1, 1'b0, 1'b0);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b0);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b0);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    scramble();
    drain();
  endtask

  // Single command on B (gap 0).
  task automatic cmd_b(input logic [0:0] rank, input logic [13:0] c1, input logic [13:0] c2,
                       input logic cs1, input logic err);
    req_type = 1'b0; b_rank = rank; b_valid = 1'b1;
    push_b(14'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    push_b(c1, cs1, 1'b0, err, 1'b0);
    push_b(c2, 1'b1, 1'b1, 1'b0, 1'b0);
    push_b(14'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    scramble();
    drain();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_rank = 2'd0; b_rank = 1'b0; req_type = 1'b0;
    mr = 8'h0; op = 8'h0; wr_addr = 9'h0; col = 8'h0; bl = 1'b0;

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_addr", a_addr, 14'h0);
    chk("rst_a_cs", 14'(a_cs), 14'h7);
    chk("rst_a_done", 14'(a_done), 14'h0);
    chk("rst_b_cs", 14'(b_cs), 14'h1);
    rst_n = 1'b1;

    // Idle after reset.
    step = 1;
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    push_b(14'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Reference MRW: mr=8, op=0x98, rank 0.
    step = 2; mr = 8'h08; op = 8'h98;
    cmd_b(1'b0, 14'h0105, 14'h0098, 1'b0, 1'b0);
    step = 3; mr = 8'h08; op = 8'h98;
    cmd_a(1'b0, 2'd0, 14'h0105, 14'h0098, 3'b110, 1'b0);

    // Rank decoding on the 3-rank instance, including out of range.
    step = 4; mr = 8'h20; op = 8'h55;
    cmd_a(1'b0, 2'd1, 14'h0405, 14'h0055, 3'b101, 1'b0);
    step = 5; mr = 8'hFF; op = 8'h01;
    cmd_a(1'b0, 2'd2, 14'h1FE5, 14'h0001, 3'b011, 1'b0);
    step = 6; mr = 8'h00; op = 8'hFF;
    cmd_a(1'b0, 2'd3, 14'h0005, 14'h00FF, 3'b111, 1'b1);
    step = 7; mr = 8'h10; op = 8'h0F;
    cmd_b(1'b1, 14'h0205, 14'h000F, 1'b1, 1'b1);

    // WRITE request (MRW encoding when WRITE support is not built).
    step = 8; mr = 8'h08; op = 8'h98; wr_addr = 9'h1A5; col = 8'h3C; bl = 1'b1;
`ifdef WRITE_CMD_EN
    cmd_a(1'b1, 2'd1, 14'h34AD, 14'h0F20, 3'b101, 1'b0);
`else
    cmd_a(1'b1, 2'd1, 14'h0105, 14'h0098, 3'b101, 1'b0);
`endif

    // Back-to-back on B with valid held: period of 3, one DES between.
    step = 9; req_type = 1'b0; b_rank = 1'b0; mr = 8'h01; op = 8'hA1; b_valid = 1'b1;
    push_b(14'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    push_b(14'h0025, 1'b0, 1'b0, 1'b0, 1'b0);
    push_b(14'h00A1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_b(14'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    push_b(14'h0045, 1'b0, 1'b0, 1'b0, 1'b0);
    push_b(14'h005B, 1'b1, 1'b1, 1'b0, 1'b0);
    push_b(14'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    mr = 8'h02; op = 8'h5B;
    repeat (3) @(posedge clk);
    #1;
    b_valid = 1'b0;
    scramble();
    drain();

    // Enable low for three cycles while in C2.
    step = 10; req_type = 1'b0; a_rank = 2'd2; mr = 8'h7F; op = 8'h3C; a_valid = 1'b1;
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    push_a(14'h0FE5, 3'b011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push_a(14'h003C, 3'b111, 1'b1, 1'b0, 1'b0);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b0);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b0);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    scramble();
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    drain();

    // Reset asserted during C1: immediate DES, no second cycle.
    step = 11; req_type = 1'b0; a_rank = 2'd0; mr = 8'h11; op = 8'h22; a_valid = 1'b1;
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    push_a(14'h0225, 3'b110, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstC1_a_addr", a_addr, 14'h0);
    chk("rstC1_a_cs", 14'(a_cs), 14'h7);
    chk("rstC1_a_done", 14'(a_done), 14'h0);
    step = 12;
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    push_a(14'h0, 3'b111, 1'b0, 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout step=%0d", step);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
